// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: ALU opcodes, ALU request bundle and scheduler sizing.
package nand_cpu_pkg;

    typedef enum logic [2:0] {
        ALU_CL,
        ALU_CP,
        ALU_NAND,
        ALU_LS,
        ALU_RS,
        ALU_EQ,
        ALU_NE,
        ALU_LI
    } AluOp;

    localparam int ALU_DATA_W  = 16;
    localparam int ALU_TAG_W   = 4;
    localparam int ALU_NUM_REQ = 2;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] op0;
        logic [ALU_DATA_W-1:0] op1;
        AluOp                  alu_op;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_req_t;

endpackage

// File: rtl/alu_input_ifc.sv
// Operand/opcode bundle feeding the execute-stage ALU.
interface alu_input_ifc #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0]  op0;
    logic [DATA_W-1:0]  op1;
    nand_cpu_pkg::AluOp alu_op;

    modport source (output op0, op1, alu_op);
    modport sink   (input  op0, op1, alu_op);
endinterface

// File: rtl/alu.sv
// Execute-stage ALU, purely combinational (zero latency, no flow control).
// Shifts by DATA_W or more give 0; EQ/NE return a zero-extended flag.
module alu import nand_cpu_pkg::*; #(
    parameter int DATA_W = 16
) (
    alu_input_ifc.sink        in_if,
    output logic [DATA_W-1:0] result
);
    localparam int NIBBLES = DATA_W / 4;

    always_comb begin
        result = '0;
        case (in_if.alu_op)
            ALU_CL:   result = '0;
            ALU_CP:   result = in_if.op0;
            ALU_NAND: result = ~(in_if.op0 & in_if.op1);
            ALU_LS:   result = in_if.op0 << in_if.op1;
            ALU_RS:   result = in_if.op0 >> in_if.op1;
            ALU_EQ:   result = {{(DATA_W-1){1'b0}}, in_if.op0 == in_if.op1};
            ALU_NE:   result = {{(DATA_W-1){1'b0}}, in_if.op0 != in_if.op1};
            ALU_LI: begin
                // op1[5:4] picks the nibble of op0 to overwrite with op1[3:0]
                result = in_if.op0;
                for (int n = 0; n < NIBBLES; n++) begin
                    if (in_if.op1[5:4] == n[1:0]) result[4*n +: 4] = in_if.op1[3:0];
                end
            end
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/alu_scheduler.sv
// Round-robin share of one ALU between two requesters; 1-cycle request->response latency.
// A full response slot blocks only its own port; a slot draining this cycle accepts a new result.
module alu_scheduler import nand_cpu_pkg::*; #(
    parameter int DATA_W = ALU_DATA_W,
    parameter int TAG_W  = ALU_TAG_W
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [ALU_NUM_REQ-1:0] req_valid,
    output logic [ALU_NUM_REQ-1:0] req_ready,
    input  logic [DATA_W-1:0]      req_op0    [ALU_NUM_REQ],
    input  logic [DATA_W-1:0]      req_op1    [ALU_NUM_REQ],
    input  AluOp                   req_alu_op [ALU_NUM_REQ],
    input  logic [TAG_W-1:0]       req_tag    [ALU_NUM_REQ],
    output logic [ALU_NUM_REQ-1:0] resp_valid,
    input  logic [ALU_NUM_REQ-1:0] resp_ready,
    output logic [DATA_W-1:0]      resp_data  [ALU_NUM_REQ],
    output logic [TAG_W-1:0]       resp_tag   [ALU_NUM_REQ],
    output logic                   busy
);
    alu_req_t                 req [ALU_NUM_REQ];
    alu_req_t                 sel_req;
    logic [ALU_NUM_REQ-1:0]   elig;
    logic [ALU_NUM_REQ-1:0]   grant;
    logic                     rr;
    logic [DATA_W-1:0]        alu_result;

    always_comb begin
        for (int i = 0; i < ALU_NUM_REQ; i++) begin
            req[i] = '{op0: req_op0[i], op1: req_op1[i], alu_op: req_alu_op[i], tag: req_tag[i]};
        end
    end

    always_comb begin
        elig  = req_valid & (~resp_valid | resp_ready);
        grant = elig;
        if (&elig) grant = rr ? 2'b10 : 2'b01;
    end

    assign req_ready = grant;
    assign busy      = |resp_valid;

    // Idle cycles present a clear op with zero operands so the ALU never decodes junk
    always_comb begin
        sel_req = '{op0: '0, op1: '0, alu_op: ALU_CL, tag: '0};
        if (grant[0])      sel_req = req[0];
        else if (grant[1]) sel_req = req[1];
    end

    alu_input_ifc #(.DATA_W(DATA_W)) alu_bus ();

    assign alu_bus.op0    = sel_req.op0;
    assign alu_bus.op1    = sel_req.op1;
    assign alu_bus.alu_op = sel_req.alu_op;

    alu #(.DATA_W(DATA_W)) u_alu (
        .in_if  (alu_bus),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr         <= 1'b0;
            resp_valid <= '0;
            for (int i = 0; i < ALU_NUM_REQ; i++) begin
                resp_data[i] <= '0;
                resp_tag[i]  <= '0;
            end
        end else begin
            // Next priority goes to the port that was not just served
            if (|grant) rr <= grant[0];
            for (int i = 0; i < ALU_NUM_REQ; i++) begin
                if (grant[i]) begin
                    resp_valid[i] <= 1'b1;
                    resp_data[i]  <= alu_result;
                    resp_tag[i]   <= sel_req.tag;
                end else if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: a reference arbiter/ALU queues expected results,
// a monitor pops and compares them whenever a response is consumed.
module tb_alu_scheduler;
    import nand_cpu_pkg::*;

    logic        clk;
    logic        n_rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_op0    [2];
    logic [15:0] req_op1    [2];
    AluOp        req_alu_op [2];
    logic [3:0]  req_tag    [2];
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_data  [2];
    logic [3:0]  resp_tag   [2];
    logic        busy;

    alu_scheduler #(.DATA_W(16), .TAG_W(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_alu_op (req_alu_op),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] sb [2][$];
    int          last_g = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input AluOp op);
        int s;
        case (op)
            ALU_CL:   return 16'h0;
            ALU_CP:   return a;
            ALU_NAND: return ~(a & b);
            ALU_LS:   return (b >= 16) ? 16'h0 : 16'(a << b);
            ALU_RS:   return (b >= 16) ? 16'h0 : 16'(a >> b);
            ALU_EQ:   return (a == b) ? 16'h1 : 16'h0;
            ALU_NE:   return (a != b) ? 16'h1 : 16'h0;
            ALU_LI: begin
                s = 4 * int'(b[5:4]);
                return (a & ~(16'hF << s)) | (16'(b[3:0]) << s);
            end
            default:  return 16'h0;
        endcase
    endfunction

    task automatic step(input logic [1:0] v, input logic [1:0] rdy);
        @(negedge clk);
        req_valid  = v;
        resp_ready = rdy;
    endtask

    task automatic set_req(input int p, input AluOp op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] t);
        req_alu_op[p] = op;
        req_op0[p]    = a;
        req_op1[p]    = b;
        req_tag[p]    = t;
    endtask

    task automatic rand_req(input int p);
        logic [15:0] b;
        b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
        set_req(p, AluOp'(3'($urandom_range(0, 7))), 16'($urandom), b, 4'($urandom));
    endtask

    // Monitor: slot occupancy and consumed results against the scoreboard
    logic [19:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (n_rst) begin
                check("busy", 32'(busy), 32'((sb[0].size() + sb[1].size()) != 0));
                for (int i = 0; i < 2; i++) begin
                    check("resp_valid", 32'(resp_valid[i]), 32'(sb[i].size() != 0));
                    if (resp_valid[i] && resp_ready[i] && sb[i].size() != 0) begin
                        mon_exp = sb[i].pop_front();
                        check("resp_data", 32'(resp_data[i]), 32'(mon_exp[15:0]));
                        check("resp_tag", 32'(resp_tag[i]), 32'(mon_exp[19:16]));
                    end
                end
            end
        end
    end

    // Reference arbiter: a port may issue if its slot is empty (after this cycle's drain)
    logic [1:0] exp_g;
    int         g;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (n_rst) begin
                exp_g = 2'b00;
                for (int i = 0; i < 2; i++) exp_g[i] = req_valid[i] && (sb[i].size() == 0);
                if (exp_g == 2'b11) exp_g = (last_g == 0) ? 2'b10 : 2'b01;
                check("req_ready", 32'(req_ready), 32'(exp_g));
                if (exp_g != 2'b00) begin
                    g = exp_g[1] ? 1 : 0;
                    sb[g].push_back({req_tag[g], ref_alu(req_op0[g], req_op1[g], req_alu_op[g])});
                    last_g = g;
                end else begin
                    check("idle_alu_op", 32'(dut.alu_bus.alu_op), 32'(ALU_CL));
                    check("idle_alu_operands", {dut.alu_bus.op0, dut.alu_bus.op1}, 32'h0);
                end
            end
        end
    end

    initial begin
        n_rst      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        for (int p = 0; p < 2; p++) set_req(p, ALU_CL, 16'h0, 16'h0, 4'h0);
        #2;
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_resp_data", {resp_data[0], resp_data[1]}, 32'h0);
        check("reset_resp_tag", 32'({resp_tag[0], resp_tag[1]}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 n_rst = 1'b1;

        // Both ports every cycle: grants must alternate starting at port 0
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 2'b11);
            set_req(0, ALU_LS, 16'h0001, 16'h0004, 4'(k));
            set_req(1, ALU_LI, 16'h1234, 16'h0025, 4'(k + 8));
            #1 check("alternate_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            #1;
            if (k == 1) check("ls_result", 32'(resp_data[0]), 32'h0010);
            if (k == 2) check("li_result", 32'(resp_data[1]), 32'h1534);
        end
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);

        // Single port 0 NAND
        step(2'b01, 2'b11);
        set_req(0, ALU_NAND, 16'hFFFF, 16'h00FF, 4'h3);
        #1 check("nand_ready", 32'(req_ready), 32'h1);
        step(2'b00, 2'b11);
        #2;
        check("nand_valid", 32'(resp_valid[0]), 32'h1);
        check("nand_data", 32'(resp_data[0]), 32'hFF00);
        check("nand_tag", 32'(resp_tag[0]), 32'h3);
        step(2'b00, 2'b11);
        #2;
        check("nand_cleared", 32'(resp_valid[0]), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // Drain and refill in the same cycle without a bubble
        step(2'b01, 2'b11);
        set_req(0, ALU_CP, 16'h1111, 16'h0000, 4'h5);
        step(2'b01, 2'b11);
        set_req(0, ALU_CP, 16'hBEEF, 16'h0000, 4'h6);
        #1;
        check("refill_ready", 32'(req_ready), 32'h1);
        check("refill_old_valid", 32'(resp_valid[0]), 32'h1);
        step(2'b00, 2'b11);
        #2;
        check("refill_valid", 32'(resp_valid[0]), 32'h1);
        check("refill_data", 32'(resp_data[0]), 32'hBEEF);

        // Back-pressure on port 1 while port 0 keeps flowing
        step(2'b11, 2'b11);
        rand_req(0);
        set_req(1, ALU_EQ, 16'h00AA, 16'h00AA, 4'h9);
        #1 check("bp_first_grant", 32'(req_ready), 32'h2);
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 2'b01);
            rand_req(0);
            #1 check("bp_port0_only", 32'(req_ready), 32'h1);
            #1;
            check("bp_held_valid", 32'(resp_valid[1]), 32'h1);
            check("bp_held_data", 32'(resp_data[1]), 32'h0001);
        end
        step(2'b11, 2'b11);
        rand_req(0);
        #1 check("bp_release_grant", 32'(req_ready), 32'h2);
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(2'($urandom), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
            rand_req(0);
            rand_req(1);
        end

        // Fill both slots, then reset mid-operation
        step(2'b11, 2'b00);
        rand_req(0);
        rand_req(1);
        step(2'b11, 2'b00);
        rand_req(0);
        rand_req(1);
        step(2'b00, 2'b00);
        #1 check("pre_reset_full", 32'(resp_valid), 32'h3);
        n_rst = 1'b0;
        sb[0].delete();
        sb[1].delete();
        last_g = 1;
        #1;
        check("async_reset_valid", 32'(resp_valid), 32'h0);
        check("async_reset_data", {resp_data[0], resp_data[1]}, 32'h0);
        check("async_reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 n_rst = 1'b1;
        step(2'b11, 2'b11);
        rand_req(0);
        rand_req(1);
        #1 check("post_reset_grant", 32'(req_ready), 32'h1);
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        step(2'b00, 2'b11);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares the single execute-stage `alu` between two requesters.
  - Port 0: main pipeline execute issue.
  - Port 1: auxiliary requester (branch-compare / debug unit).
- Valid/ready handshake on every request and response channel.
- Round-robin arbitration between the two ports.
- Each port has a one-entry registered response slot, so the block has real sequencing and back-pressure.

Parameters:
- DATA_W, 16, operand/result width; must match the `alu` width.
- TAG_W, 4, width of the requester-supplied tag, returned unchanged with the result.

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- req_valid  input  2  per-port request valid
- req_ready  output  2  per-port request accepted this cycle
- req_op0  input  2xDATA_W  per-port operand 0
- req_op1  input  2xDATA_W  per-port operand 1
- req_alu_op  input  2xAluOp  per-port operation
- req_tag  input  2xTAG_W  per-port tag
- resp_valid  output  2  per-port result valid
- resp_ready  input  2  per-port result consumed
- resp_data  output  2xDATA_W  per-port result
- resp_tag  output  2xTAG_W  per-port tag of the result
- busy  output  1  high when either resp_valid bit is set

Behaviour:
- Reset (async assert on n_rst=0):
  - resp_valid=0, resp_data=0, resp_tag=0.
  - Round-robin pointer rr=0 (port 0 has priority).
  - Any in-flight result is dropped; requesters reissue.
  - Release is synchronised to clk by the surrounding reset logic.
- Eligibility: elig[i] = req_valid[i] & (~resp_valid[i] | resp_ready[i]). A slot that is being drained this cycle counts as free.
- Grant (combinational, at most one per cycle):
  - Only one port eligible: that port is granted.
  - Both eligible: port rr is granted.
  - req_ready = grant (one-hot or zero).
  - No combinational path from req_valid[j] to req_ready[i] when i≠j, except through the arbitration itself.
- Pointer: on any grant to port g, rr <= ~g next cycle. With no grant, rr holds. A continuously requesting port therefore waits at most 1 cycle.
- ALU drive:
  - Granted port: its op0/op1/alu_op go to the `alu`.
  - No grant: op0=op1=0 and alu_op=ALU_CL, so the ALU never sees an X or undecoded op.
- Latency: exactly 1 cycle. The grant in cycle N gives resp_valid[g]=1 in cycle N+1, with resp_data = ALU result and resp_tag = req_tag[g] captured at N.
- Slot update per port i, each cycle:
  - Grant to i: load new result, resp_valid stays/becomes 1. This also covers the case where resp_ready[i] drains the old result in the same cycle.
  - No grant, resp_valid[i] & resp_ready[i]: resp_valid[i] <= 0. resp_data/resp_tag hold their last value.
  - Otherwise: hold.
- Back-pressure:
  - With resp_valid[i]=1 and resp_ready[i]=0, port i is not eligible.
  - The other port continues to be served.
- Undefined alu_op encodings: the result is whatever the `alu` produces; the scheduler does not filter them. The requester owns legality.
- Width rules:
  - EQ/NE results are zero-extended 1-bit values.
  - LI uses op1[5:4] as the nibble select and op1[3:0] as the data.
  - Shift amount is op1 taken unsigned; a shift of DATA_W or more yields 0.
- busy = |resp_valid.

Decomposition:
- nand_cpu_pkg already holds the AluOp enum (ALU_CL, ALU_CP, ALU_NAND, ALU_LS, ALU_RS, ALU_EQ, ALU_NE, ALU_LI).
- Add to nand_cpu_pkg:
  - typedef struct alu_req_t {op0, op1, alu_op, tag}.
  - localparam ALU_NUM_REQ=2.
- Sub-module: one instance of the existing `alu`, driven through an alu_input_ifc.
- Arbitration and slots stay inline.
  - An optional rr_arb2 helper is permitted but not required.

Test Plan:
- Single port 0 NAND: op0=0xFFFF, op1=0x00FF, tag=3, resp_ready=1 → req_ready[0] same cycle; next cycle resp_valid[0]=1, resp_data[0]=0xFF00, resp_tag[0]=3, then cleared.
- Both ports valid every cycle, both resp_ready=1:
  - Port 0 LS 0x0001<<4, port 1 LI op0=0x1234, op1=0x0025.
  - Required: grants alternate 0,1,0,1 starting with port 0; results 0x0010 and 0x1534.
- Back-pressure: port 1 resp_ready=0 after its first result.
  - Port 1 EQ 0x00AA,0x00AA gives resp_data[1]=0x0001 and resp_valid[1] held.
  - req_ready[1] stays 0 while port 0 is granted every cycle.
  - Raise resp_ready[1]: port 1 is granted in the same cycle it drains.
- Drain-and-refill: resp_valid[0]=1 and resp_ready[0]=1 with a new port-0 CP 0xBEEF in the same cycle → resp_valid[0] stays 1 with no bubble; next resp_data[0]=0xBEEF.
- Idle: no req_valid → the ALU sees ALU_CL with zero operands, rr unchanged, busy=0.
- Reset mid-operation: assert n_rst low with resp_valid=2'b11 → resp_valid=0, resp_data=0 immediately (asynchronously); after release, the first simultaneous request is granted to port 0.
